// File: rtl/bsg_alu_pkg.sv
// rtl/bsg_alu_pkg.sv - shared ALU op codes, requester FSM states and width helper
package bsg_alu_pkg;

  typedef enum logic [1:0] {
    e_alu_and  = 2'b00,
    e_alu_xor  = 2'b01,
    e_alu_nand = 2'b10,
    e_alu_add  = 2'b11
  } bsg_alu_op_e;

  typedef enum logic [1:0] {
    e_idle = 2'b00,
    e_wait = 2'b01,
    e_done = 2'b10
  } bsg_alu_req_state_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int bsg_safe_clog2(input int x);
    int r;
    r = (x <= 1) ? 1 : $clog2(x);
    return r;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// rtl/bsg_counter_clear_up.sv - up counter with synchronous clear and async reset
module bsg_counter_clear_up
  import bsg_alu_pkg::*;
#(
  parameter int max_val_p    = 1,
  parameter int ptr_width_lp = bsg_safe_clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  // Clear takes priority; a simultaneous up starts the new count at one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= ptr_width_lp'(up_i);
    end else if (up_i) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_alu_req_master.sv
// rtl/bsg_alu_req_master.sv - issues one ALU op at a time and returns its result
module bsg_alu_req_master
  import bsg_alu_pkg::*;
#(
  parameter int width_p       = 0,  // must be overridden by the instantiating module
  parameter int lat_p         = 0,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [1:0]               op_i,
  input  logic [width_p-1:0]       a_i,
  input  logic [width_p-1:0]       b_i,
  output logic                     ready_o,
  output logic [1:0]               alu_control_o,
  output logic [width_p-1:0]       alu_a_o,
  output logic [width_p-1:0]       alu_b_o,
  input  logic [width_p-1:0]       alu_res_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [1:0]               op_o,
  input  logic                     yumi_i,
  output logic [count_width_p-1:0] count_o
);

  localparam int wait_width_lp = bsg_safe_clog2(lat_p + 1);

  bsg_alu_req_state_e state_r, state_n;

  logic [wait_width_lp-1:0] wait_cnt;
  logic                     load;
  logic                     capture;
  logic                     consume;
  logic                     wait_up;
  logic                     wait_last;

  assign wait_last = (wait_cnt == wait_width_lp'(lat_p));

  // Counts ALU settle cycles; restarted from zero on every accepted request.
  bsg_counter_clear_up #(
    .max_val_p(lat_p)
  ) wait_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(load),
    .up_i   (wait_up),
    .count_o(wait_cnt)
  );

  // State register; reset aborts any op in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    wait_up = 1'b0;
    case (state_r)
      e_idle: begin
        ready_o = ~reset_i;
        if (v_i) begin
          load    = 1'b1;
          state_n = e_wait;
        end
      end
      e_wait: begin
        if (wait_last) begin
          capture = 1'b1;
          state_n = e_done;
        end else begin
          wait_up = 1'b1;
        end
      end
      e_done: begin
        v_o = 1'b1;
        if (yumi_i) begin
          consume = 1'b1;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Operand/control registers feeding the ALU, result capture and completion count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_control_o <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      data_o        <= '0;
      op_o          <= '0;
      count_o       <= '0;
    end else begin
      if (load) begin
        alu_control_o <= op_i;
        alu_a_o       <= a_i;
        alu_b_o       <= b_i;
      end
      if (capture) begin
        data_o <= alu_res_i;
        op_o   <= alu_control_o;
      end
      if (consume) begin
        count_o <= count_o + 1'b1;
      end
    end
  end

  // A consumer may only take a result that is being presented.
  yumi_only_in_done: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> (state_r == e_done));

endmodule

// File: tb/tb_bsg_alu_req_master.sv
// tb/tb_bsg_alu_req_master.sv - randomized self-checking bench for bsg_alu_req_master
module tb_bsg_alu_req_master;

  localparam int W = 8;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v_i = 1'b0;
  logic         yumi = 1'b0;
  logic [1:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] alu_res;

  logic         ready, v_o, ready_w, v_o_w;
  logic [1:0]   ctrl, op_o, ctrl_w, op_o_w;
  logic [W-1:0] alu_a, alu_b, data, alu_a_w, alu_b_w, data_w;
  logic [15:0]  cnt;
  logic [1:0]   cnt_w;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  bsg_alu_req_master #(.width_p(W), .lat_p(L), .count_width_p(16)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready), .alu_control_o(ctrl), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_res_i(alu_res), .v_o(v_o), .data_o(data), .op_o(op_o),
    .yumi_i(yumi), .count_o(cnt)
  );

  bsg_alu_req_master #(.width_p(W), .lat_p(L), .count_width_p(2)) dut_w (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_w), .alu_control_o(ctrl_w), .alu_a_o(alu_a_w), .alu_b_o(alu_b_w),
    .alu_res_i(alu_res), .v_o(v_o_w), .data_o(data_w), .op_o(op_o_w),
    .yumi_i(yumi), .count_o(cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int s;
    case (op)
      2'd0: r = a & b;
      2'd1: r = a ^ b;
      2'd2: r = ~(a & b);
      default: begin
        s = int'(a) + int'(b);
        r = W'(s % (1 << W));
      end
    endcase
    return r;
  endfunction

  // Reference ALU responder: result valid only after operands held L cycles, X otherwise.
  int           stable = 0;
  logic [1:0]   pc = '0;
  logic [W-1:0] pa = '0, pb = '0;
  always @(negedge clk) begin
    if (ctrl !== pc || alu_a !== pa || alu_b !== pb) stable = 0;
    else if (stable < 1000) stable = stable + 1;
    pc = ctrl;
    pa = alu_a;
    pb = alu_b;
  end
  assign alu_res = (stable >= L) ? alu_fn(ctrl, alu_a, alu_b) : 'x;

  // Scoreboard of accepted ops and their expected results.
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] res;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cyc = 0;
  int prev_acc = -1;
  bit stream = 1'b0;
  bit v_prev = 1'b0;
  bit cnt_chk = 1'b0;
  int consumed = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      consumed = 0;
      v_prev = 1'b0;
      cnt_chk = 1'b0;
    end else begin
      if (cnt_chk) begin
        check("count_o", 32'(cnt), 32'(consumed % 65536));
        check("count_o_w2", 32'(cnt_w), 32'(consumed % 4));
        cnt_chk = 1'b0;
      end
      if (v_o && !v_prev) check("latency", 32'(cyc - acc_cyc), 32'(L + 2));
      if (v_o && yumi) begin
        if (q.size() == 0) begin
          check("spurious_v_o", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("data_o", 32'(data), 32'(e.res));
          check("op_o", 32'(op_o), 32'(e.op));
        end
        consumed++;
        cnt_chk = 1'b1;
      end
      if (v_i && ready) begin
        e.op = op_i;
        e.res = alu_fn(op_i, a_i, b_i);
        q.push_back(e);
        if (stream && prev_acc >= 0) check("interval", 32'(cyc - prev_acc), 32'(L + 3));
        prev_acc = cyc;
        acc_cyc = cyc;
      end
      v_prev = v_o;
    end
  end

  // Always-willing consumer that only takes a presented result.
  bit cons_en = 1'b1;
  initial forever begin
    @(posedge clk);
    #1;
    yumi = v_o && cons_en;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_i = op;
    a_i = a;
    b_i = b;
    v_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        tick();
        return;
      end
    end
    check("issue_timeout", 32'(0), 32'(1));
    tick();
  endtask

  task automatic drain();
    v_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0 && !v_o) return;
      tick();
    end
    check("drain_timeout", 32'(0), 32'(1));
  endtask

  logic [1:0]   t_op[4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [W-1:0] t_a[4]  = '{8'hFF, 8'hF0, 8'hAA, 8'hC3};
  logic [W-1:0] t_b[4]  = '{8'h02, 8'hFF, 8'h0F, 8'h3C};
  logic [W-1:0] t_e[4]  = '{8'h01, 8'h0F, 8'hA5, 8'h00};
  int           wrap_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    #1;
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_v_o", 32'(v_o), 32'(0));
    check("rst_count", 32'(cnt), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_alu", 32'({ctrl, alu_a, alu_b, op_o}), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'(1));
    tick();

    issue(2'd3, 8'h7F, 8'h01);
    drain();
    check("add_data", 32'(data), 32'(8'h80));
    check("add_op", 32'(op_o), 32'(2'd3));
    check("add_count", 32'(cnt), 32'(1));

    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      drain();
      check("dir_data", 32'(data), 32'(t_e[i]));
      check("dir_op", 32'(op_o), 32'(t_op[i]));
    end
    check("dir_count", 32'(cnt), 32'(5));

    cons_en = 1'b0;
    issue(2'd1, 8'h3C, 8'h55);
    v_i = 1'b0;
    for (int i = 0; i < 20 && !v_o; i++) tick();
    for (int i = 0; i < 5; i++) begin
      op_i = 2'($urandom_range(0, 3));
      a_i = W'($urandom);
      b_i = W'($urandom);
      v_i = (i % 2 == 0);
      @(negedge clk);
      check("bp_v_o", 32'(v_o), 32'(1));
      check("bp_data", 32'(data), 32'(8'h69));
      check("bp_op", 32'(op_o), 32'(2'd1));
      check("bp_ready", 32'(ready), 32'(0));
      check("bp_alu", 32'({ctrl, alu_a, alu_b}), 32'({2'd1, 8'h3C, 8'h55}));
      check("bp_count", 32'(cnt), 32'(5));
      tick();
    end
    v_i = 1'b0;
    cons_en = 1'b1;
    drain();
    check("bp_count_after", 32'(cnt), 32'(6));

    stream = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 10; i++) issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    drain();
    stream = 1'b0;
    check("stream_count", 32'(cnt), 32'(16));

    issue(2'd3, 8'h11, 8'h22);
    drain();
    check("pre_rst_data", 32'(data), 32'(8'h33));
    issue(2'd2, 8'h55, 8'h0F);
    v_i = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_v_o", 32'(v_o), 32'(0));
    check("mid_rst_data", 32'(data), 32'(0));
    check("mid_rst_alu", 32'({ctrl, alu_a, alu_b}), 32'(0));
    check("mid_rst_ready", 32'(ready), 32'(0));
    check("mid_rst_count", 32'(cnt), 32'(0));
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'(1));
    check("post_rst_count", 32'(cnt), 32'(0));
    check("post_rst_count_w", 32'(cnt_w), 32'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_v_o", 32'(v_o), 32'(0));
    end
    tick();

    for (int i = 0; i < 5; i++) begin
      issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      drain();
      check("wrap_count", 32'(cnt_w), 32'(wrap_seq[i]));
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    check("watchdog", 32'(0), 32'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bsg_alu_req_master.md
Name: bsg_alu_req_master

Overview:
- Requester side of the team's N-bit ALU interface.
- Accepts one operation at a time on a valid/ready input channel and drives the ALU operand and control lines from registers.
- Waits a fixed, parameterised ALU latency, then captures the result and presents it on a valid/yumi output channel.
- Sits between a command source (sequencer or test driver) and a combinational or pipelined ALU responder.

Parameters:
- width_p, no default (must be set), operand and result width.
- lat_p, default 0, extra ALU cycles needed after operands are stable before the result is valid.
- count_width_p, default 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  request valid.
- op_i  in  2  operation code: 00 AND, 01 XOR, 10 NAND, 11 ADD.
- a_i  in  width_p  operand A.
- b_i  in  width_p  operand B.
- ready_o  out  1  request accepted when v_i & ready_o.
- alu_control_o  out  2  registered op code driven to the ALU.
- alu_a_o  out  width_p  registered operand A driven to the ALU.
- alu_b_o  out  width_p  registered operand B driven to the ALU.
- alu_res_i  in  width_p  ALU result.
- v_o  out  1  result valid.
- data_o  out  width_p  captured result.
- op_o  out  2  op code of the result currently presented.
- yumi_i  in  1  consumer takes result; legal only when v_o=1.
- count_o  out  count_width_p  number of results consumed; wraps.

Behaviour:
- Reset is asynchronous, active-high. While reset_i=1 and after release:
  - state=IDLE
  - ready_o=0 during reset, 1 once reset_i is low
  - v_o=0
  - data_o, op_o, alu_control_o, alu_a_o, alu_b_o, count_o and the wait counter = 0
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - ready_o=1.
  - On v_i=1: latch op_i/a_i/b_i into the ALU-driving registers, clear the wait counter, go to WAIT.
  - Otherwise hold, and the ALU outputs keep their last values.
- WAIT:
  - ready_o=0; ALU outputs held stable.
  - The wait counter increments each cycle.
  - In the cycle where the counter equals lat_p: capture alu_res_i into data_o and alu_control_o into op_o, then go to DONE.
  - With lat_p=0, WAIT lasts exactly one cycle.
- DONE:
  - v_o=1; data_o and op_o held stable; ready_o=0.
  - On yumi_i=1: count_o increments by 1, modulo 2^count_width_p, and the FSM goes to IDLE.
  - No same-cycle accept of a new request.
- Latency and throughput:
  - Accept edge to first v_o=1 cycle is lat_p+2 cycles.
  - Minimum issue interval is lat_p+3 cycles, with yumi_i asserted in the first DONE cycle.
- Arithmetic: none performed internally. Results are taken from alu_res_i unmodified; ADD carry-out is not observed, so the result is the sum modulo 2^width_p.
- Boundary conditions:
  - v_i outside IDLE is ignored; the source must hold the request until ready_o.
  - yumi_i outside DONE is a protocol violation; flag it with an assertion, and state must not change.
  - Back-pressure: DONE is held indefinitely with data_o stable.
  - Reset in WAIT or DONE aborts the operation: the result is discarded, no v_o pulse occurs, and count_o is not incremented.
  - count_o wraps from all-ones to 0.
- Wait counter width is `BSG_SAFE_CLOG2(lat_p+1).

Decomposition:
- Shared package bsg_alu_pkg holds:
  - enum bsg_alu_op_e, 2 bits: e_alu_and=2'b00, e_alu_xor=2'b01, e_alu_nand=2'b10, e_alu_add=2'b11
  - FSM state enum bsg_alu_req_state_e: e_idle, e_wait, e_done
- Reuse bsg_counter_clear_up as the single sub-module for the latency wait counter.
- The completed-op counter is inline.

Test Plan:
Bench uses width_p=8, lat_p=2, with a reference ALU responder that delays results 2 cycles and goes to X when operands change.
1. ADD: a=0x7F, b=0x01, yumi_i tied high -> v_o rises 4 cycles after accept with data_o=0x80, op_o=11; count_o=1 after the yumi.
2. ADD overflow: a=0xFF, b=0x02 -> data_o=0x01. NAND: a=0xF0, b=0xFF -> data_o=0x0F. XOR: a=0xAA, b=0x0F -> data_o=0xA5. AND: a=0xC3, b=0x3C -> data_o=0x00.
3. Back-pressure: yumi_i low for 5 cycles in DONE while v_i pulses new ops -> v_o, data_o and op_o are stable; ready_o=0; no new op is latched; count_o is unchanged until the yumi.
4. Back-to-back stream: 10 random ops with v_i held high and yumi_i=1 -> each accept is 5 cycles apart, results match the model in order, count_o=10.
5. Reset mid-op: assert reset_i asynchronously (mid-cycle) in the second WAIT cycle -> v_o, data_o and alu_* outputs go to 0 immediately; after release ready_o=1 and count_o=0; no stale v_o.
6. Counter wrap: count_width_p=2, 5 completed ops -> count_o sequence 1,2,3,0,1.
